// File: rtl/l2_prefetcher_pkg.sv
// rtl/l2_prefetcher_pkg.sv - shared line-geometry constant and FSM state type for the L2 prefetcher
package l2_prefetcher_pkg;

  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_ISSUE = 2'd1,
    PF_VALID = 2'd2,
    PF_SERVE = 2'd3
  } pf_state_t;

endpackage

// File: rtl/pf_sat_counter.sv
// rtl/pf_sat_counter.sv - event counter that sticks at all-ones
module pf_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && !(&count))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/register.sv
// rtl/register.sv - loadable register with synchronous active-high clear
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/l2_prefetcher.sv
// rtl/l2_prefetcher.sv - next-line prefetcher answering L2 reads that hit its single line buffer
// Optional statistics counters are built only when PF_STATS_EN is defined.
module l2_prefetcher
  import l2_prefetcher_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = LINE_OFFSET_BITS,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L2_read,
  input  logic                  L2_write,
  input  logic [ADDR_WIDTH-1:0] L2_addr,
  input  logic                  L2_arb_resp,
  output logic                  pf_resp,
  output logic [LINE_WIDTH-1:0] pf_rdata,
  output logic                  pre_read,
  output logic [ADDR_WIDTH-1:0] pre_addr,
  input  logic [LINE_WIDTH-1:0] arb_pre_rdata,
  input  logic                  arb_pre_resp,
  output logic [CNT_WIDTH-1:0]  pf_issue_cnt,
  output logic [CNT_WIDTH-1:0]  pf_hit_cnt
);

  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;

  pf_state_t             state, next_state;
  logic                  stale, stale_next;
  logic                  addr_load, buf_load;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [TAG_W-1:0]      l2_tag, pre_tag;
  logic                  match, rd_match, wr_match, demand_miss;
  logic                  unused_offset;

  assign l2_tag        = L2_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign pre_tag       = pre_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign match         = (l2_tag == pre_tag);
  assign rd_match      = L2_read & match;
  assign wr_match      = L2_write & match;
  assign demand_miss   = L2_arb_resp & L2_read & ~match;
  assign unused_offset = ^L2_addr[OFFSET_BITS-1:0];

  // Line address only moves when entering ISSUE; the top line has no successor.
  always_comb begin
    next_state = state;
    stale_next = stale;
    addr_load  = 1'b0;
    addr_d     = pre_addr;
    buf_load   = 1'b0;
    case (state)
      PF_EMPTY: begin
        if (rd_match) begin
          next_state = PF_ISSUE;
        end else if (demand_miss && !(&l2_tag)) begin
          addr_load  = 1'b1;
          addr_d     = {l2_tag + TAG_W'(1), {OFFSET_BITS{1'b0}}};
          next_state = PF_ISSUE;
        end
      end
      PF_ISSUE: begin
        if (arb_pre_resp) begin
          buf_load = 1'b1;
          if (stale) begin
            stale_next = 1'b0;
            next_state = PF_EMPTY;
          end else if (rd_match) begin
            next_state = PF_SERVE;
          end else begin
            next_state = PF_VALID;
          end
        end else if (wr_match) begin
          stale_next = 1'b1;
        end
      end
      PF_VALID: begin
        if (wr_match) begin
          next_state = PF_EMPTY;
        end else if (rd_match) begin
          next_state = PF_SERVE;
        end else if (demand_miss && !(&l2_tag)) begin
          addr_load  = 1'b1;
          addr_d     = {l2_tag + TAG_W'(1), {OFFSET_BITS{1'b0}}};
          next_state = PF_ISSUE;
        end
      end
      PF_SERVE: begin
        if (&pre_tag) begin
          next_state = PF_VALID;
        end else begin
          addr_load  = 1'b1;
          addr_d     = {pre_tag + TAG_W'(1), {OFFSET_BITS{1'b0}}};
          next_state = PF_ISSUE;
        end
      end
      default: next_state = PF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PF_EMPTY;
      stale    <= 1'b0;
      pre_read <= 1'b0;
      pf_resp  <= 1'b0;
    end else begin
      state    <= next_state;
      stale    <= stale_next;
      pre_read <= (next_state == PF_ISSUE);
      pf_resp  <= (next_state == PF_SERVE);
    end
  end

  register #(.WIDTH(ADDR_WIDTH)) u_pre_addr (
    .clk   (clk),
    .reset (reset),
    .load  (addr_load),
    .d     (addr_d),
    .q     (pre_addr)
  );

  register #(.WIDTH(LINE_WIDTH)) u_line_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .d     (arb_pre_rdata),
    .q     (pf_rdata)
  );

`ifdef PF_STATS_EN
  logic issue_inc, hit_inc;

  assign issue_inc = (next_state == PF_ISSUE) && (state != PF_ISSUE);
  assign hit_inc   = (state == PF_SERVE);

  pf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_issue_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (issue_inc),
    .count (pf_issue_cnt)
  );

  pf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (pf_hit_cnt)
  );
`else
  assign pf_issue_cnt = '0;
  assign pf_hit_cnt   = '0;
`endif

endmodule

// File: tb/tb_l2_prefetcher.sv
// tb/tb_l2_prefetcher.sv - directed scoreboard bench for l2_prefetcher (honours PF_STATS_EN)
module tb_l2_prefetcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         L2_read, L2_write, L2_arb_resp, arb_pre_resp;
  logic [31:0]  L2_addr;
  logic [255:0] arb_pre_rdata;
  logic         pf_resp, pre_read;
  logic [255:0] pf_rdata;
  logic [31:0]  pre_addr;
  logic [15:0]  pf_issue_cnt, pf_hit_cnt;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [255:0] exp_q[$];
  logic [255:0] mon_exp;

`ifdef PF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  l2_prefetcher dut (
    .clk           (clk),
    .reset         (reset),
    .L2_read       (L2_read),
    .L2_write      (L2_write),
    .L2_addr       (L2_addr),
    .L2_arb_resp   (L2_arb_resp),
    .pf_resp       (pf_resp),
    .pf_rdata      (pf_rdata),
    .pre_read      (pre_read),
    .pre_addr      (pre_addr),
    .arb_pre_rdata (arb_pre_rdata),
    .arb_pre_resp  (arb_pre_resp),
    .pf_issue_cnt  (pf_issue_cnt),
    .pf_hit_cnt    (pf_hit_cnt)
  );

  function automatic logic [255:0] mk_line(input int n);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = 32'hDA00_0000 + 32'(n) * 32'h100 + 32'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pre_return(input logic [255:0] d);
    arb_pre_resp  = 1'b1;
    arb_pre_rdata = d;
    tick();
    arb_pre_resp  = 1'b0;
  endtask

  task automatic demand_miss(input logic [31:0] a);
    L2_read = 1'b1;
    L2_addr = a;
    tick();
    tick();
    L2_arb_resp = 1'b1;
    tick();
    L2_read     = 1'b0;
    L2_arb_resp = 1'b0;
  endtask

  // Every pf_resp pulse must consume exactly one queued line.
  always @(negedge clk) begin
    if (reset === 1'b0 && pf_resp === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pf_resp_unexpected: got pf_resp=1 expected no response pending");
      end else begin
        mon_exp = exp_q.pop_front();
        if (pf_rdata !== mon_exp) begin
          miscompares++;
          $display("FAIL pf_rdata: got %h expected %h", pf_rdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; L2_read = 1'b0; L2_write = 1'b0; L2_arb_resp = 1'b0;
    arb_pre_resp = 1'b0; L2_addr = '0; arb_pre_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk1("reset_pre_read", pre_read, 1'b0);
    chk("reset_pre_addr", pre_addr, 32'h0);
    chk1("reset_pf_resp", pf_resp, 1'b0);
    chk("reset_issue_cnt", 32'(pf_issue_cnt), 32'd0);
    chk("reset_hit_cnt", 32'(pf_hit_cnt), 32'd0);

    // 1: read of address 0 right after reset fetches line 0
    L2_read = 1'b1; L2_addr = 32'h0;
    tick();
    chk1("t1_pre_read", pre_read, 1'b1);
    chk("t1_pre_addr", pre_addr, 32'h0);
    exp_q.push_back(mk_line(1));
    pre_return(mk_line(1));
    chk1("t1_pf_resp", pf_resp, 1'b1);
    chk1("t1_pre_read_drop", pre_read, 1'b0);
    L2_read = 1'b0;
    tick();
    chk1("t1_pf_resp_once", pf_resp, 1'b0);
    chk("t1_next_addr", pre_addr, 32'h20);
    chk1("t1_next_issue", pre_read, 1'b1);
    pre_return(mk_line(2));
    chk1("t1_valid_idle", pre_read, 1'b0);

    // 2: demand miss prefetches the next line, later read hits it
    demand_miss(32'h0000_1040);
    chk1("t2_pre_read", pre_read, 1'b1);
    chk("t2_pre_addr", pre_addr, 32'h0000_1060);
    pre_return(mk_line(3));
    chk1("t2_no_resp", pf_resp, 1'b0);
    L2_read = 1'b1; L2_addr = 32'h0000_1064;
    exp_q.push_back(mk_line(3));
    tick();
    chk1("t2_pf_resp", pf_resp, 1'b1);
    L2_read = 1'b0;
    tick();
    chk("t2_advance", pre_addr, 32'h0000_1080);
    chk1("t2_advance_issue", pre_read, 1'b1);

    // 3: read waiting on an in-flight prefetch
    pre_return(mk_line(4));
    demand_miss(32'h0000_2040);
    chk("t3_pre_addr", pre_addr, 32'h0000_2060);
    L2_read = 1'b1; L2_addr = 32'h0000_2060;
    tick(); tick(); tick();
    chk1("t3_wait", pf_resp, 1'b0);
    exp_q.push_back(mk_line(5));
    pre_return(mk_line(5));
    chk1("t3_pf_resp", pf_resp, 1'b1);
    L2_read = 1'b0;
    tick();
    chk1("t3_once", pf_resp, 1'b0);
    chk("t3_advance", pre_addr, 32'h0000_2080);
    pre_return(mk_line(6));

    // 4: write to the in-flight line drops the data
    demand_miss(32'h0000_2FE0);
    chk("t4_pre_addr", pre_addr, 32'h0000_3000);
    L2_write = 1'b1; L2_addr = 32'h0000_3000;
    tick(); tick();
    pre_return(mk_line(7));
    chk1("t4_dropped", pre_read, 1'b0);
    chk1("t4_no_resp", pf_resp, 1'b0);
    L2_arb_resp = 1'b1;
    tick();
    L2_write = 1'b0; L2_arb_resp = 1'b0;
    tick();
    chk1("t4_idle_resp", pf_resp, 1'b0);
    chk1("t4_idle_read", pre_read, 1'b0);
    L2_read = 1'b1; L2_addr = 32'h0000_3000;
    tick();
    chk1("t4_refetch", pre_read, 1'b1);
    chk("t4_refetch_addr", pre_addr, 32'h0000_3000);
    exp_q.push_back(mk_line(8));
    pre_return(mk_line(8));
    chk1("t4_pf_resp", pf_resp, 1'b1);
    L2_read = 1'b0;
    tick();
    chk("t4_advance", pre_addr, 32'h0000_3020);
    pre_return(mk_line(9));

    // 5: invalidate by write, then a miss at the top line must not prefetch
    L2_write = 1'b1; L2_addr = 32'h0000_3020;
    tick();
    L2_arb_resp = 1'b1;
    tick();
    L2_write = 1'b0; L2_arb_resp = 1'b0;
    demand_miss(32'hFFFF_FFE0);
    chk1("t5_no_prefetch", pre_read, 1'b0);
    chk("t5_addr_kept", pre_addr, 32'h0000_3020);
    tick();
    chk1("t5_still_idle", pre_read, 1'b0);
    L2_read = 1'b1; L2_addr = 32'h0000_3020;
    tick();
    chk1("t5_empty_refetch", pre_read, 1'b1);
    chk1("t5_no_stale_hit", pf_resp, 1'b0);
    exp_q.push_back(mk_line(10));
    pre_return(mk_line(10));
    chk1("t5_pf_resp", pf_resp, 1'b1);
    L2_read = 1'b0;
    tick();
    chk("t5_advance", pre_addr, 32'h0000_3040);
    chk("t5_issue_cnt", 32'(pf_issue_cnt), STATS ? 32'd11 : 32'd0);
    chk("t5_hit_cnt", 32'(pf_hit_cnt), STATS ? 32'd5 : 32'd0);

    // reset while a prefetch is in flight, then a late response
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rst2_pre_read", pre_read, 1'b0);
    chk("rst2_pre_addr", pre_addr, 32'h0);
    chk("rst2_issue_cnt", 32'(pf_issue_cnt), 32'd0);
    chk("rst2_hit_cnt", 32'(pf_hit_cnt), 32'd0);
    pre_return(mk_line(11));
    chk1("late_resp_ignored", pre_read, 1'b0);
    tick();
    chk1("late_resp_no_pf", pf_resp, 1'b0);

    // 6: three issues, two hits
    L2_read = 1'b1; L2_addr = 32'h0;
    tick();
    exp_q.push_back(mk_line(12));
    pre_return(mk_line(12));
    L2_read = 1'b0;
    tick();
    pre_return(mk_line(13));
    L2_read = 1'b1; L2_addr = 32'h0000_0024;
    exp_q.push_back(mk_line(13));
    tick();
    chk1("t6_pf_resp", pf_resp, 1'b1);
    L2_read = 1'b0;
    tick();
    chk("t6_pre_addr", pre_addr, 32'h0000_0040);
    chk("t6_issue_cnt", 32'(pf_issue_cnt), STATS ? 32'd3 : 32'd0);
    chk("t6_hit_cnt", 32'(pf_hit_cnt), STATS ? 32'd2 : 32'd0);

    // serving the top line keeps the buffer and address
    pre_return(mk_line(14));
    demand_miss(32'hFFFF_FFC0);
    chk("top_pre_addr", pre_addr, 32'hFFFF_FFE0);
    pre_return(mk_line(15));
    L2_read = 1'b1; L2_addr = 32'hFFFF_FFE8;
    exp_q.push_back(mk_line(15));
    tick();
    chk1("top_pf_resp", pf_resp, 1'b1);
    L2_read = 1'b0;
    tick();
    chk1("top_no_issue", pre_read, 1'b0);
    chk("top_addr_kept", pre_addr, 32'hFFFF_FFE0);
    chk("top_issue_cnt", 32'(pf_issue_cnt), STATS ? 32'd4 : 32'd0);
    chk("top_hit_cnt", 32'(pf_hit_cnt), STATS ? 32'd3 : 32'd0);

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
